// File: rtl/tick_timer_pkg.sv
// Shared types and BCD helpers for the mm:ss countdown timer.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [3:0] BCD_NINE = 4'h9;

  // Both nibbles must be decimal digits; comparing valid BCD bytes as binary preserves order.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= BCD_NINE) && (value[3:0] <= BCD_NINE) && (value <= max);
  endfunction

endpackage

// File: rtl/tick_countdown_if.sv
// Control/status bundle between the countdown timer and its surrounding logic.
interface tick_countdown_if;

  logic       tick_in;
  logic       clear;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       done;
  logic       load_err;

  modport master (
    output tick_in, clear, load, load_min, load_sec, start, pause,
    input  min_bcd, sec_bcd, running, expired, done, load_err
  );

  modport slave (
    input  tick_in, clear, load, load_min, load_sec, start, pause,
    output min_bcd, sec_bcd, running, expired, done, load_err
  );

endinterface

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second BCD decrement of an mm:ss value, with a zero-result flag.
module bcd_mmss_dec
  import tick_timer_pkg::*;
#(
  parameter logic [7:0] SEC_MAX = 8'h59
) (
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       zero_o
);

  // A byte already at 00 stays at 00; the caller never decrements 00:00.
  function automatic logic [7:0] dec_byte(input logic [7:0] v);
    if (v[3:0] != 4'h0) begin
      return {v[7:4], v[3:0] - 4'h1};
    end else if (v[7:4] != 4'h0) begin
      return {v[7:4] - 4'h1, BCD_NINE};
    end else begin
      return BCD_ZERO;
    end
  endfunction

  always_comb begin
    min_o = min_i;
    sec_o = dec_byte(sec_i);
    if (sec_i == BCD_ZERO) begin
      sec_o = SEC_MAX;
      min_o = dec_byte(min_i);
    end
    zero_o = (min_o == BCD_ZERO) && (sec_o == BCD_ZERO);
  end

endmodule

// File: rtl/tick_countdown.sv
// BCD mm:ss countdown timer driven by a 1 Hz tick strobe.
// Define TICK_EDGE_EN to synchronise tick_in and count only its rising edges.
module tick_countdown
  import tick_timer_pkg::*;
#(
  parameter logic [7:0] SEC_MAX = 8'h59,
  parameter logic [7:0] MIN_MAX = 8'h59
) (
  input  logic             system_clk,
  input  logic             r,
  tick_countdown_if.slave  bus
);

  state_e     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       running_q;
  logic       expired_q, expired_d;
  logic       done_q;
  logic       loadErr_q, loadErr_d;

  logic       tickEff;
  logic [7:0] decMin, decSec;
  logic       decZero;
  logic       valueZero;
  logic       loadOk;
  logic       canLoad;
  logic       canStart;

`ifdef TICK_EDGE_EN
  // Two sync flops plus a history flop; a rising edge is seen two cycles after tick_in rises.
  logic [2:0] tickSync_q;

  always_ff @(posedge system_clk or posedge r) begin
    if (r) begin
      tickSync_q <= 3'b000;
    end else begin
      tickSync_q <= {tickSync_q[1:0], bus.tick_in};
    end
  end

  assign tickEff = tickSync_q[1] & ~tickSync_q[2];
`else
  assign tickEff = bus.tick_in;
`endif

  bcd_mmss_dec #(
    .SEC_MAX (SEC_MAX)
  ) u_dec (
    .min_i  (min_q),
    .sec_i  (sec_q),
    .min_o  (decMin),
    .sec_o  (decSec),
    .zero_o (decZero)
  );

  assign valueZero = (min_q == BCD_ZERO) && (sec_q == BCD_ZERO);
  assign loadOk    = bcd_valid(bus.load_min, MIN_MAX) && bcd_valid(bus.load_sec, SEC_MAX);
  assign canLoad   = (state_q == IDLE) || (state_q == EXPIRED);
  assign canStart  = (state_q == IDLE) || (state_q == PAUSED);

  // Only the highest-priority asserted control acts; a tick counts only when no control is asserted.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    expired_d = 1'b0;
    loadErr_d = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      min_d   = BCD_ZERO;
      sec_d   = BCD_ZERO;
    end else if (bus.load) begin
      if (canLoad) begin
        if (loadOk) begin
          state_d = IDLE;
          min_d   = bus.load_min;
          sec_d   = bus.load_sec;
        end else begin
          loadErr_d = 1'b1;
        end
      end
    end else if (bus.start) begin
      if (canStart) begin
        if (valueZero) begin
          state_d   = EXPIRED;
          expired_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end else if (bus.pause) begin
      if (state_q == RUN) begin
        state_d = PAUSED;
      end
    end else if (tickEff && (state_q == RUN)) begin
      min_d = decMin;
      sec_d = decSec;
      if (decZero) begin
        state_d   = EXPIRED;
        expired_d = 1'b1;
      end
    end
  end

  // Status flags are registered from the next state so they line up with the value they describe.
  always_ff @(posedge system_clk or posedge r) begin
    if (r) begin
      state_q   <= IDLE;
      min_q     <= BCD_ZERO;
      sec_q     <= BCD_ZERO;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      loadErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= (state_d == RUN);
      expired_q <= expired_d;
      done_q    <= (state_d == EXPIRED);
      loadErr_q <= loadErr_d;
    end
  end

  assign bus.min_bcd  = min_q;
  assign bus.sec_bcd  = sec_q;
  assign bus.running  = running_q;
  assign bus.expired  = expired_q;
  assign bus.done     = done_q;
  assign bus.load_err = loadErr_q;

endmodule

// File: tb/tb_tick_countdown.sv
// Self-checking bench for tick_countdown: an integer-seconds model checked every cycle plus directed literals.
module tb_tick_countdown;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSED  = 2;
  localparam int M_EXPIRED = 3;

  logic system_clk = 1'b0;
  logic r          = 1'b0;
  int   errCount   = 0;
  int   checkCount = 0;
  logic compareEn  = 1'b0;

  tick_countdown_if bus ();

  tick_countdown #(
    .SEC_MAX (8'h59),
    .MIN_MAX (8'h59)
  ) dut (
    .system_clk (system_clk),
    .r          (r),
    .bus        (bus)
  );

  always #5 system_clk = ~system_clk;

  // Model keeps the remaining time as a plain count of seconds.
  int   mState, mTotal;
  logic mExp, mErr;
  int   nState, nTotal;
  logic nExp, nErr;
  logic tickNow;
  logic [2:0] tickHist;

  function automatic int fromBcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] toBcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic okByte(input logic [7:0] b);
    return (b[7:4] < 4'd10) && (b[3:0] < 4'd10) && (fromBcd(b) <= 59);
  endfunction

  always_comb begin
`ifdef TICK_EDGE_EN
    tickNow = tickHist[1] & ~tickHist[2];
`else
    tickNow = bus.tick_in;
`endif
    nState = mState;
    nTotal = mTotal;
    nExp   = 1'b0;
    nErr   = 1'b0;
    if (bus.clear) begin
      nState = M_IDLE;
      nTotal = 0;
    end else if (bus.load) begin
      if (mState == M_IDLE || mState == M_EXPIRED) begin
        if (okByte(bus.load_min) && okByte(bus.load_sec)) begin
          nState = M_IDLE;
          nTotal = fromBcd(bus.load_min) * 60 + fromBcd(bus.load_sec);
        end else begin
          nErr = 1'b1;
        end
      end
    end else if (bus.start) begin
      if (mState == M_IDLE || mState == M_PAUSED) begin
        if (mTotal == 0) begin
          nState = M_EXPIRED;
          nExp   = 1'b1;
        end else begin
          nState = M_RUN;
        end
      end
    end else if (bus.pause) begin
      if (mState == M_RUN) nState = M_PAUSED;
    end else if (tickNow && mState == M_RUN) begin
      nTotal = mTotal - 1;
      if (nTotal == 0) begin
        nState = M_EXPIRED;
        nExp   = 1'b1;
      end
    end
  end

  always @(posedge system_clk or posedge r) begin
    if (r) begin
      mState   <= M_IDLE;
      mTotal   <= 0;
      mExp     <= 1'b0;
      mErr     <= 1'b0;
      tickHist <= 3'b000;
    end else begin
      mState   <= nState;
      mTotal   <= nTotal;
      mExp     <= nExp;
      mErr     <= nErr;
      tickHist <= {tickHist[1:0], bus.tick_in};
    end
  end

  task automatic compareOne(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL model %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge system_clk) begin
    if (compareEn) begin
      compareOne("min_bcd",  bus.min_bcd,        toBcd(mTotal / 60));
      compareOne("sec_bcd",  bus.sec_bcd,        toBcd(mTotal % 60));
      compareOne("running",  {7'd0, bus.running},  {7'd0, (mState == M_RUN)});
      compareOne("done",     {7'd0, bus.done},     {7'd0, (mState == M_EXPIRED)});
      compareOne("expired",  {7'd0, bus.expired},  {7'd0, mExp});
      compareOne("load_err", {7'd0, bus.load_err}, {7'd0, mErr});
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                               input logic st, input logic p, input logic t);
    bus.clear    = c;
    bus.load     = l;
    bus.load_min = lm;
    bus.load_sec = ls;
    bus.start    = st;
    bus.pause    = p;
    bus.tick_in  = t;
    @(negedge system_clk);
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doLoad(input logic [7:0] lm, input logic [7:0] ls);
    applyStimulus(1'b0, 1'b1, lm, ls, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doStart();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doPause();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // A single tick pulse, followed in edge mode by the cycles the synchronizer needs.
  task automatic tickStep();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef TICK_EDGE_EN
    idleStep();
    idleStep();
`endif
  endtask

  initial begin
    bus.clear = 1'b0; bus.load = 1'b0; bus.load_min = 8'h00; bus.load_sec = 8'h00;
    bus.start = 1'b0; bus.pause = 1'b0; bus.tick_in = 1'b0;
    #2 r = 1'b1;
    @(negedge system_clk);
    checkOutput("reset min", bus.min_bcd, 8'h00);
    checkOutput("reset sec", bus.sec_bcd, 8'h00);
    checkOutput("reset running", {7'd0, bus.running}, 8'h00);
    checkOutput("reset done", {7'd0, bus.done}, 8'h00);
    r = 1'b0;
    compareEn = 1'b1;
    idleStep();

    $display("[TB] 00:03 countdown");
    doLoad(8'h00, 8'h03);
    checkOutput("load 0003 sec", bus.sec_bcd, 8'h03);
    doStart();
    checkOutput("start running", {7'd0, bus.running}, 8'h01);
    tickStep();
    checkOutput("tick1 sec", bus.sec_bcd, 8'h02);
    tickStep();
    checkOutput("tick2 sec", bus.sec_bcd, 8'h01);
    tickStep();
    checkOutput("tick3 sec", bus.sec_bcd, 8'h00);
    checkOutput("tick3 expired", {7'd0, bus.expired}, 8'h01);
    checkOutput("tick3 done", {7'd0, bus.done}, 8'h01);
    checkOutput("tick3 running", {7'd0, bus.running}, 8'h00);
    idleStep();
    checkOutput("expired one cycle", {7'd0, bus.expired}, 8'h00);
    checkOutput("done sticky", {7'd0, bus.done}, 8'h01);

    $display("[TB] 01:00 countdown");
    doLoad(8'h01, 8'h00);
    checkOutput("load clears done", {7'd0, bus.done}, 8'h00);
    doStart();
    tickStep();
    checkOutput("borrow min", bus.min_bcd, 8'h00);
    checkOutput("borrow sec", bus.sec_bcd, 8'h59);
    for (int i = 0; i < 58; i++) tickStep();
    checkOutput("58 more sec", bus.sec_bcd, 8'h01);
    tickStep();
    checkOutput("60th tick sec", bus.sec_bcd, 8'h00);
    checkOutput("60th tick expired", {7'd0, bus.expired}, 8'h01);

    $display("[TB] load validation");
    doLoad(8'h00, 8'h1A);
    checkOutput("bad nibble err", {7'd0, bus.load_err}, 8'h01);
    checkOutput("bad nibble sec kept", bus.sec_bcd, 8'h00);
    idleStep();
    checkOutput("load_err one cycle", {7'd0, bus.load_err}, 8'h00);
    doLoad(8'h00, 8'h60);
    checkOutput("sec 60 err", {7'd0, bus.load_err}, 8'h01);
    doLoad(8'h60, 8'h00);
    checkOutput("min 60 err", {7'd0, bus.load_err}, 8'h01);
    doLoad(8'h10, 8'h00);
    doStart();
    tickStep();
    checkOutput("10:00 min", bus.min_bcd, 8'h09);
    checkOutput("10:00 sec", bus.sec_bcd, 8'h59);
    doClear();
    doLoad(8'h00, 8'h05);
    doStart();
    doLoad(8'h00, 8'h10);
    checkOutput("load in run no err", {7'd0, bus.load_err}, 8'h00);
    checkOutput("load in run ignored", bus.sec_bcd, 8'h05);

    $display("[TB] pause and resume");
    doPause();
    checkOutput("paused running", {7'd0, bus.running}, 8'h00);
    for (int i = 0; i < 4; i++) tickStep();
    checkOutput("paused hold", bus.sec_bcd, 8'h05);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("resume running", {7'd0, bus.running}, 8'h01);
`ifdef TICK_EDGE_EN
    idleStep();
    idleStep();
`else
    checkOutput("start+tick discarded", bus.sec_bcd, 8'h05);
    tickStep();
`endif
    checkOutput("tick after resume", bus.sec_bcd, 8'h04);

    $display("[TB] zero start and clear");
    doClear();
    checkOutput("clear done", {7'd0, bus.done}, 8'h00);
    doLoad(8'h00, 8'h00);
    doStart();
    checkOutput("zero start expired", {7'd0, bus.expired}, 8'h01);
    checkOutput("zero start done", {7'd0, bus.done}, 8'h01);
    idleStep();
    checkOutput("zero expired once", {7'd0, bus.expired}, 8'h00);
    tickStep();
    tickStep();
    checkOutput("expired ticks ignored", bus.sec_bcd, 8'h00);
    doClear();
    checkOutput("clear after expiry", {7'd0, bus.done}, 8'h00);

    $display("[TB] async reset mid run");
    doLoad(8'h00, 8'h30);
    doStart();
    checkOutput("pre-reset running", {7'd0, bus.running}, 8'h01);
    #3 r = 1'b1;
    #1;
    checkOutput("async running", {7'd0, bus.running}, 8'h00);
    checkOutput("async sec", bus.sec_bcd, 8'h00);
    checkOutput("async expired", {7'd0, bus.expired}, 8'h00);
    @(negedge system_clk);
    r = 1'b0;
    idleStep();

    $display("[TB] held tick");
    doLoad(8'h00, 8'h20);
    doStart();
`ifdef TICK_EDGE_EN
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idleStep();
    idleStep();
    idleStep();
    checkOutput("held tick once", bus.sec_bcd, 8'h19);
`else
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idleStep();
    checkOutput("held tick each cycle", bus.sec_bcd, 8'h17);
`endif

    compareEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tick_countdown.md
Name: tick_countdown

Overview:
- BCD minutes:seconds countdown timer that consumes the one-cycle 1 Hz strobe produced by the clock tick generator.
- Loads a preset, then decrements once per accepted tick.
- Flags expiry with a one-cycle pulse and a sticky level.
- Sits beside the tick generator in the same system_clk domain; outputs drive the display and control logic.

Parameters:
- SEC_MAX, 8'h59, BCD value seconds wrap to on minute borrow; also the load-validity ceiling for seconds.
- MIN_MAX, 8'h59, BCD load-validity ceiling for minutes.

Ports:
- system_clk  input  1  system clock; all state updates on its rising edge.
- r  input  1  asynchronous active-high reset.
- tick_in  input  1  tick strobe from the clock tick generator; high for one system_clk cycle per second.
- clear  input  1  return to IDLE with 00:00.
- load  input  1  capture load_min/load_sec.
- load_min  input  8  BCD minutes preset.
- load_sec  input  8  BCD seconds preset.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- min_bcd  output  8  current minutes, BCD.
- sec_bcd  output  8  current seconds, BCD.
- running  output  1  high while in RUN.
- expired  output  1  one-cycle pulse on reaching 00:00.
- done  output  1  sticky high while in EXPIRED.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Single clock is system_clk; reset r is asynchronous, active-high. On r: state=IDLE, min_bcd=8'h00, sec_bcd=8'h00, running=0, expired=0, done=0, load_err=0. Reset mid-count aborts immediately; no pulse is generated.
- States:
  - IDLE: loaded/held value, not counting.
  - RUN: counting.
  - PAUSED: value held.
  - EXPIRED: 00:00 reached.
- Control priority per cycle: clear > load > start > pause > tick_in. Only the highest-priority active control acts.
- clear, any state: -> IDLE, value=00:00, done=0.
- load:
  - Accepted only in IDLE or EXPIRED.
  - Valid when both nibbles of each byte are <=9, load_sec<=SEC_MAX and load_min<=MIN_MAX. Valid load: value=preset, ->IDLE, done=0.
  - Invalid load: value unchanged, load_err=1 for one cycle.
  - In RUN/PAUSED: ignored, no load_err.
- start:
  - IDLE or PAUSED with value != 00:00: ->RUN.
  - IDLE or PAUSED with value == 00:00: ->EXPIRED, expired pulse on the next cycle.
  - Ignored in RUN and EXPIRED.
- pause: RUN->PAUSED; ignored elsewhere.
- tick_in:
  - Acts only in RUN and only in a cycle with no control input active. A tick in the same cycle as start is discarded; counting begins on the following tick.
  - Decrement:
    - sec low nibble !=0: low-1.
    - sec low nibble ==0, sec !=00: low=9, high-1.
    - sec ==00: sec=SEC_MAX, min decremented by the same BCD rule.
  - If the decremented value is 00:00: ->EXPIRED on that edge, expired=1 for exactly one cycle starting that edge, done=1 held until clear or a valid load.
- Latency: tick_in sampled high at edge N -> new value visible after edge N.
- running = (state==RUN), registered.
- Outputs are always valid BCD; no arithmetic produces nibble >9.
- Ticks in IDLE/PAUSED/EXPIRED are ignored.

Optional Feature:
- Macro TICK_EDGE_EN.
- Defined: tick_in passes through a 2-flop synchronizer plus rising-edge detector, so a level or slow-clock source is accepted. Effective tick latency is +2 cycles; a tick held high for many cycles counts once.
- Undefined: tick_in is used directly as a one-cycle strobe; a held-high tick_in decrements every cycle while in RUN.

Decomposition:
- Package tick_timer_pkg:
  - state enum (IDLE, RUN, PAUSED, EXPIRED);
  - BCD constants BCD_ZERO=8'h00, BCD_NINE=4'h9;
  - function bcd_valid(byte, max).
- Sub-module bcd_mmss_dec: combinational, takes min/sec, returns decremented min/sec plus a zero flag. Instantiated once.

Test Plan:
- Load 00:03, start, 3 ticks -> sec 02,01,00; expired pulse exactly one cycle after the 3rd tick edge; done=1; running=0.
- Load 01:00, start, 1 tick -> 00:59; 59 more ticks -> 00:00 and expired.
- Load 8'h1A sec -> load_err one cycle, value unchanged. Load sec 8'h60 -> load_err. Load during RUN -> ignored, no load_err.
- Running at 00:05: pause, 4 ticks -> value stays 00:05. Start plus tick in the same cycle -> still 00:05; next tick -> 00:04.
- Load 00:00, start -> EXPIRED, expired one pulse; subsequent ticks -> no change. Clear -> 00:00 IDLE, done=0.
- r asserted asynchronously mid-RUN at 00:30 -> all outputs zero immediately, IDLE. With TICK_EDGE_EN, tick_in held high 10 cycles -> single decrement.
